// File: rtl/mtx_pkg.sv
// Shared types and constants for the matrix-multiply loop sequencer.
// The tag widths follow DIM_LOG2_DEF; keep the sequencer's DIM_LOG2 equal to it.
package mtx_pkg;

    localparam int DIM_LOG2_DEF = 3;
    localparam int IDX_W        = DIM_LOG2_DEF;
    localparam int DIM          = 1 << DIM_LOG2_DEF;
    localparam int ADDR_W       = 2 * IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // One operand read in flight towards the MAC.
    typedef struct packed {
        logic             vld;
        logic             first;
        logic             last;
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
    } tag_t;

    // One finished dot product in flight towards C write-back.
    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] c_addr;
    } wr_tag_t;

endpackage

// File: rtl/loop_cnt.sv
// Mod-2^W loop counter with carry in/out for cascading into a loop nest.
// Zero latency carry-out; advances only when CE and C_IN are both high.
module loop_cnt #(
    parameter int W = 3
) (
    input  logic         CLK,
    input  logic         CE,
    input  logic         CLR,
    input  logic         C_IN,
    output logic         C_OUT,
    output logic [W-1:0] Q
);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            Q <= '0;
        end else if (CE && C_IN) begin
            Q <= Q + W'(1);
        end
    end

    assign C_OUT = C_IN & (&Q);

endmodule

// File: rtl/mtx_mul_seq.sv
// i/j/k loop sequencer: operand reads, MAC clear/enable/last, C write strobes.
// RD_EN one cycle after a RUN cycle; HOLD stalls issue, in-flight tags keep draining.
module mtx_mul_seq
    import mtx_pkg::*;
#(
    parameter int DIM_LOG2 = DIM_LOG2_DEF,
    parameter int RD_LAT   = 1,
    parameter int MAC_LAT  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic                  HOLD,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  RD_EN,
    output logic [2*DIM_LOG2-1:0] A_ADDR,
    output logic [2*DIM_LOG2-1:0] B_ADDR,
    output logic                  MAC_EN,
    output logic                  MAC_CLR,
    output logic                  MAC_LAST,
    output logic                  WR_EN,
    output logic [2*DIM_LOG2-1:0] C_ADDR
);

    state_t           state;
    logic [IDX_W-1:0] i_q, j_q, k_q;
    logic             k_co, j_co, i_co;
    logic             kill, issue, pending;
    tag_t             issue_tag;
    tag_t             mac_line [RD_LAT];
    wr_tag_t          wr_line  [MAC_LAT];

    // RST and an ABORT while active both flush everything back to IDLE.
    assign kill  = RST | (ABORT & ((state == ST_RUN) | (state == ST_DRAIN)));
    assign issue = (state == ST_RUN) & ~HOLD;

    loop_cnt #(.W(IDX_W)) u_k (
        .CLK(CLK), .CE(issue), .CLR(kill), .C_IN(1'b1), .C_OUT(k_co), .Q(k_q)
    );
    loop_cnt #(.W(IDX_W)) u_j (
        .CLK(CLK), .CE(issue), .CLR(kill), .C_IN(k_co), .C_OUT(j_co), .Q(j_q)
    );
    loop_cnt #(.W(IDX_W)) u_i (
        .CLK(CLK), .CE(issue), .CLR(kill), .C_IN(j_co), .C_OUT(i_co), .Q(i_q)
    );

    // The last write stage is already on the outputs, so it does not hold off DONE.
    always_comb begin
        pending = issue_tag.vld;
        for (int s = 0; s < RD_LAT; s++) begin
            pending = pending | mac_line[s].vld;
        end
        for (int s = 0; s < MAC_LAT - 1; s++) begin
            pending = pending | wr_line[s].vld;
        end
    end

    always_ff @(posedge CLK) begin
        if (kill) begin
            state     <= ST_IDLE;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            RD_EN     <= 1'b0;
            A_ADDR    <= '0;
            B_ADDR    <= '0;
            issue_tag <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                mac_line[s] <= '0;
            end
            for (int s = 0; s < MAC_LAT; s++) begin
                wr_line[s] <= '0;
            end
        end else begin
            RD_EN     <= issue;
            DONE      <= 1'b0;
            issue_tag <= '0;
            if (issue) begin
                A_ADDR          <= {i_q, k_q};
                B_ADDR          <= {k_q, j_q};
                issue_tag.vld   <= 1'b1;
                issue_tag.first <= (k_q == '0);
                issue_tag.last  <= (k_q == IDX_W'(DIM - 1));
                issue_tag.i     <= i_q;
                issue_tag.j     <= j_q;
            end

            mac_line[0] <= issue_tag;
            for (int s = 1; s < RD_LAT; s++) begin
                mac_line[s] <= mac_line[s-1];
            end

            wr_line[0].vld    <= mac_line[RD_LAT-1].vld & mac_line[RD_LAT-1].last;
            wr_line[0].c_addr <= {mac_line[RD_LAT-1].i, mac_line[RD_LAT-1].j};
            for (int s = 1; s < MAC_LAT; s++) begin
                wr_line[s] <= wr_line[s-1];
            end

            case (state)
                ST_IDLE: begin
                    if (START && !ABORT) begin
                        state <= ST_RUN;
                        BUSY  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issue && i_co) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!pending) begin
                        state <= ST_DONE;
                        DONE  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    assign MAC_EN   = mac_line[RD_LAT-1].vld;
    assign MAC_CLR  = mac_line[RD_LAT-1].first;
    assign MAC_LAST = mac_line[RD_LAT-1].last;
    assign WR_EN    = wr_line[MAC_LAT-1].vld;
    assign C_ADDR   = wr_line[MAC_LAT-1].c_addr;

endmodule

// File: tb/tb_mtx_mul_seq.sv
// Bench for mtx_mul_seq: event-timeline reference model checked every cycle,
// plus a table of full-run timing landmarks and directed abort/reset sequences.
module tb_mtx_mul_seq;

    localparam int DL    = 3;
    localparam int RDL   = 1;
    localparam int MCL   = 2;
    localparam int N     = 1 << DL;
    localparam int TOTAL = N * N * N;

    logic          CLK = 1'b0;
    logic          RST, START, ABORT, HOLD;
    logic          BUSY, DONE, RD_EN, MAC_EN, MAC_CLR, MAC_LAST, WR_EN;
    logic [2*DL-1:0] A_ADDR, B_ADDR, C_ADDR;

    mtx_mul_seq #(.DIM_LOG2(DL), .RD_LAT(RDL), .MAC_LAT(MCL)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .HOLD(HOLD),
        .BUSY(BUSY), .DONE(DONE), .RD_EN(RD_EN), .A_ADDR(A_ADDR), .B_ADDR(B_ADDR),
        .MAC_EN(MAC_EN), .MAC_CLR(MAC_CLR), .MAC_LAST(MAC_LAST),
        .WR_EN(WR_EN), .C_ADDR(C_ADDR)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: the multiply as a list of TOTAL issues in k,j,i order,
    // with downstream events scheduled on a timeline of future cycles.
    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mmode_t;
    mmode_t m_mode = M_IDLE;
    int  m_n = 0;
    int  m_done_at = -1;
    int  e_a = 0, e_b = 0;
    bit  a_known = 1'b0, e_busy = 1'b0, e_rd = 1'b0;
    bit  r_mac[16], r_clr[16], r_last[16], r_wr[16], r_done[16];
    int  r_c[16];

    // Per-run trace of what the DUT did.
    int t_first_rd, t_last_rd, t_first_wr, t_last_wr, t_done, t_rd_cnt, t_wr_cnt;
    int t_done_cnt, t_mac_cnt, t_first_a, t_first_b;

    typedef struct {
        int hold_n;
        int hold_len;
        int first_wr;
        int last_rd;
        int last_wr;
        int done;
        int rd_cnt;
        int wr_cnt;
    } row_t;
    row_t rows[3];

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic ring_clear();
        for (int s = 0; s < 16; s++) begin
            r_mac[s] = 0; r_clr[s] = 0; r_last[s] = 0;
            r_wr[s] = 0; r_done[s] = 0; r_c[s] = 0;
        end
    endtask

    task automatic trace_reset();
        t_first_rd = -1; t_last_rd = -1; t_first_wr = -1; t_last_wr = -1;
        t_done = -1; t_rd_cnt = 0; t_wr_cnt = 0; t_done_cnt = 0; t_mac_cnt = 0;
        t_first_a = -1; t_first_b = -1;
    endtask

    // Predict outputs for cycle cyc+1 from the inputs applied at the coming edge.
    task automatic model_step(input bit st, input bit ab, input bit hd, input bit rs);
        int nc, t, i, j, k;
        nc = cyc + 1;
        if (rs || (ab && (m_mode == M_RUN || m_mode == M_DRAIN))) begin
            ring_clear();
            m_mode = M_IDLE; m_n = 0; e_busy = 0; e_rd = 0; m_done_at = -1;
            if (rs) begin
                e_a = 0; e_b = 0; a_known = 1;
            end else begin
                a_known = 0;
            end
        end else begin
            e_rd = 0;
            case (m_mode)
                M_IDLE: begin
                    if (st && !ab) begin
                        m_mode = M_RUN; e_busy = 1;
                    end
                end
                M_RUN: begin
                    if (!hd) begin
                        k = m_n % N; j = (m_n / N) % N; i = m_n / (N * N);
                        e_rd = 1; e_a = i * N + k; e_b = k * N + j; a_known = 1;
                        t = nc + RDL;
                        r_mac[t % 16] = 1; r_clr[t % 16] = (k == 0); r_last[t % 16] = (k == N - 1);
                        if (k == N - 1) begin
                            r_wr[(t + MCL) % 16] = 1; r_c[(t + MCL) % 16] = i * N + j;
                        end
                        if (m_n == TOTAL - 1) begin
                            m_done_at = t + MCL + 1;
                            r_done[m_done_at % 16] = 1;
                            m_mode = M_DRAIN; m_n = 0;
                        end else begin
                            m_n++;
                        end
                    end
                end
                M_DRAIN: begin
                    if (nc == m_done_at) m_mode = M_DONE;
                end
                default: begin
                    m_mode = M_IDLE; e_busy = 0;
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        int s;
        s = cyc % 16;
        chk("busy", int'(BUSY), int'(e_busy));
        chk("done", int'(DONE), int'(r_done[s]));
        chk("rd_en", int'(RD_EN), int'(e_rd));
        chk("mac_en", int'(MAC_EN), int'(r_mac[s]));
        if (r_mac[s]) begin
            chk("mac_clr", int'(MAC_CLR), int'(r_clr[s]));
            chk("mac_last", int'(MAC_LAST), int'(r_last[s]));
        end
        chk("wr_en", int'(WR_EN), int'(r_wr[s]));
        if (r_wr[s]) chk("c_addr", int'(C_ADDR), r_c[s]);
        if (a_known) begin
            chk("a_addr", int'(A_ADDR), e_a);
            chk("b_addr", int'(B_ADDR), e_b);
        end
        r_mac[s] = 0; r_clr[s] = 0; r_last[s] = 0; r_wr[s] = 0; r_done[s] = 0;
    endtask

    task automatic tick(input bit st, input bit ab, input bit hd, input bit rs);
        START = st; ABORT = ab; HOLD = hd; RST = rs;
        model_step(st, ab, hd, rs);
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        check_outputs();
        if (RD_EN) begin
            if (t_first_rd < 0) begin
                t_first_rd = cyc; t_first_a = int'(A_ADDR); t_first_b = int'(B_ADDR);
            end
            t_last_rd = cyc; t_rd_cnt++;
        end
        if (WR_EN) begin
            if (t_first_wr < 0) t_first_wr = cyc;
            t_last_wr = cyc; t_wr_cnt++;
        end
        if (MAC_EN) t_mac_cnt++;
        if (DONE) begin
            t_done = cyc; t_done_cnt++;
        end
    endtask

    task automatic run_to_idle(input int hold_pct, input bit spam, input int abort_per_mil,
                               input int budget);
        int c;
        c = 0;
        while (m_mode != M_IDLE && c < budget) begin
            tick(spam && ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 999) < abort_per_mil),
                 ($urandom_range(0, 99) < hold_pct), 1'b0);
            c++;
        end
        chk("run_ends_busy_low", int'(BUSY), 0);
    endtask

    initial begin
        int hcnt;
        bit h;
        int c;

        rows[0] = '{-1,  0, 10, 511, 514, 515, TOTAL, N * N};
        rows[1] = '{ 4,  5, 15, 516, 519, 520, TOTAL, N * N};
        rows[2] = '{511, 3, 10, 514, 517, 518, TOTAL, N * N};

        ring_clear();
        trace_reset();
        for (int r = 0; r < 3; r++) tick(0, 0, 0, 1);
        for (int r = 0; r < 2; r++) tick(0, 0, 0, 0);

        // Full runs with timing landmarks relative to the first RD_EN.
        for (int r = 0; r < 3; r++) begin
            hcnt = 0;
            trace_reset();
            tick(1, 0, 0, 0);
            c = 0;
            while (m_mode != M_IDLE && c < 1500) begin
                h = (m_mode == M_RUN && m_n == rows[r].hold_n && hcnt < rows[r].hold_len);
                if (h) hcnt++;
                tick(0, 0, h, 0);
                c++;
            end
            tick(0, 0, 0, 0);
            chk($sformatf("row%0d_first_wr", r), t_first_wr - t_first_rd, rows[r].first_wr);
            chk($sformatf("row%0d_last_rd", r), t_last_rd - t_first_rd, rows[r].last_rd);
            chk($sformatf("row%0d_last_wr", r), t_last_wr - t_first_rd, rows[r].last_wr);
            chk($sformatf("row%0d_done", r), t_done - t_first_rd, rows[r].done);
            chk($sformatf("row%0d_rd_cnt", r), t_rd_cnt, rows[r].rd_cnt);
            chk($sformatf("row%0d_wr_cnt", r), t_wr_cnt, rows[r].wr_cnt);
            chk($sformatf("row%0d_busy_after", r), int'(BUSY), 0);
        end

        // START pulses during RUN/DRAIN are ignored: one DONE only.
        trace_reset();
        tick(1, 0, 0, 0);
        run_to_idle(10, 1'b1, 0, 2000);
        for (int r = 0; r < 4; r++) tick(0, 0, 0, 0);
        chk("spam_one_done", t_done_cnt, 1);
        tick(1, 1, 0, 0);
        tick(0, 0, 0, 0);
        chk("start_abort_busy", int'(BUSY), 0);

        // ABORT partway through i=2, then a clean restart from address 0.
        tick(1, 0, 0, 0);
        c = 0;
        while (!(m_mode == M_RUN && m_n == 2 * N * N + 5) && c < 1000) begin
            tick(0, 0, ($urandom_range(0, 3) == 0), 0);
            c++;
        end
        tick(0, 1, 0, 0);
        chk("abort_busy", int'(BUSY), 0);
        trace_reset();
        for (int r = 0; r < 10; r++) tick(0, 0, 0, 0);
        chk("abort_quiet", t_mac_cnt + t_wr_cnt + t_done_cnt, 0);
        trace_reset();
        tick(1, 0, 0, 0);
        run_to_idle(20, 1'b0, 0, 2000);
        chk("restart_a0", t_first_a, 0);
        chk("restart_b0", t_first_b, 0);
        chk("restart_done", t_done_cnt, 1);

        // RST during DRAIN clears every output on the next cycle.
        tick(1, 0, 0, 0);
        c = 0;
        while (m_mode != M_DRAIN && c < 1000) begin
            tick(0, 0, 0, 0);
            c++;
        end
        tick(0, 0, 0, 1);
        chk("rst_drain_outs", int'(|{BUSY, DONE, RD_EN, MAC_EN, MAC_CLR, MAC_LAST, WR_EN,
                                   A_ADDR, B_ADDR, C_ADDR}), 0);
        trace_reset();
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        run_to_idle(0, 1'b0, 0, 2000);
        chk("rst_restart_done", t_done_cnt, 1);

        // Randomised runs: heavy HOLD, stray START and occasional ABORT.
        for (int r = 0; r < 3; r++) begin
            tick(1, 0, 0, 0);
            run_to_idle(30, 1'b1, 2, 3000);
            tick(0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
